// File: rtl/mm_pkg.sv
// Shared FSM state type, master identifier and default widths for the MM arbiter.
package mm_pkg;

    localparam int MM_ADDR_WIDTH_DEF = 8;
    localparam int MM_DATA_WIDTH_DEF = 16;
    localparam int HOLD_LIMIT_DEF    = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

endpackage

// File: rtl/mm_arbiter_if.sv
// Bundle of the two master ports, the shared MM port and arbiter status.
// slave = arbiter side, master = the side driving requests and read data.
interface mm_arbiter_if
    import mm_pkg::*;
#(
    parameter int ADDR_W = MM_ADDR_WIDTH_DEF,
    parameter int DATA_W = MM_DATA_WIDTH_DEF
);
    logic              m0_req_i;
    logic              m0_stb_i;
    logic              m0_we_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic              m0_gnt_o;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_rvalid_o;

    logic              m1_req_i;
    logic              m1_stb_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic              m1_gnt_o;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              m1_rvalid_o;

    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_wdata_o;
    logic              s_we_o;
    logic [DATA_W-1:0] s_rdata_i;
    logic [1:0]        arb_owner_o;
    logic              arb_timeout_o;

    modport slave (
        input  m0_req_i, m0_stb_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m1_req_i, m1_stb_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  s_rdata_i,
        output m0_gnt_o, m0_rdata_o, m0_rvalid_o,
        output m1_gnt_o, m1_rdata_o, m1_rvalid_o,
        output s_addr_o, s_wdata_o, s_we_o, arb_owner_o, arb_timeout_o
    );

    modport master (
        output m0_req_i, m0_stb_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m1_req_i, m1_stb_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output s_rdata_i,
        input  m0_gnt_o, m0_rdata_o, m0_rvalid_o,
        input  m1_gnt_o, m1_rdata_o, m1_rvalid_o,
        input  s_addr_o, s_wdata_o, s_we_o, arb_owner_o, arb_timeout_o
    );

endinterface

// File: rtl/mm_arb_mux.sv
// Registered MM request mux and read-return tag pipeline: an accepted read at t
// drives the bus at t+1 and returns rdata/rvalid to its master at t+2.
module mm_arb_mux
    import mm_pkg::*;
#(
    parameter int AW = MM_ADDR_WIDTH_DEF,
    parameter int DW = MM_DATA_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          acc,
    input  logic [1:0]          we,
    input  logic [1:0][AW-1:0]  addr,
    input  logic [1:0][DW-1:0]  wdata,
    input  logic [DW-1:0]       s_rdata,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_wdata,
    output logic                s_we,
    output logic                rd_pending,
    output logic [1:0]          rvalid,
    output logic [1:0][DW-1:0]  rdata
);
    logic [AW-1:0] s_addr_reg;
    logic [DW-1:0] s_wdata_reg;
    logic          s_we_reg;
    logic          tag_valid_reg;
    master_t       tag_id_reg;
    logic          sel;

    // At most one master is granted, so acc is one-hot or zero.
    assign sel = acc[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_addr_reg    <= '0;
            s_wdata_reg   <= '0;
            s_we_reg      <= 1'b0;
            tag_valid_reg <= 1'b0;
            tag_id_reg    <= M0;
        end else begin
            s_we_reg      <= 1'b0;
            tag_valid_reg <= 1'b0;
            if (|acc) begin
                s_addr_reg    <= addr[sel];
                s_wdata_reg   <= wdata[sel];
                s_we_reg      <= we[sel];
                tag_valid_reg <= ~we[sel];
                tag_id_reg    <= sel ? M1 : M0;
            end
        end
    end

    assign s_addr     = s_addr_reg;
    assign s_wdata    = s_wdata_reg;
    assign s_we       = s_we_reg;
    assign rd_pending = tag_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            logic          rvalid_reg;
            logic [DW-1:0] rdata_reg;
            logic          hit;

            assign hit = tag_valid_reg && (tag_id_reg == ((gi == 1) ? M1 : M0));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= hit;
                    if (hit) begin
                        rdata_reg <= s_rdata;
                    end
                end
            end

            assign rvalid[gi] = rvalid_reg;
            assign rdata[gi]  = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/mm_arbiter.sv
// Two-master arbiter for one MM port: IDLE -> OWNx -> (DRAIN) -> IDLE, fair on contention.
// Define MM_ARB_TIMEOUT_EN to revoke ownership after HOLD_LIMIT granted cycles.
module mm_arbiter
    import mm_pkg::*;
#(
    parameter int MM_ADDR_WIDTH = MM_ADDR_WIDTH_DEF,
    parameter int MM_DATA_WIDTH = MM_DATA_WIDTH_DEF,
    parameter int HOLD_LIMIT    = HOLD_LIMIT_DEF
) (
    input  logic         clk_sys_i,
    input  logic         rst_i,
    mm_arbiter_if.slave  bus
);
    arb_state_t state_reg, state_next;
    master_t    last_reg, last_next;
    master_t    own;

    logic [1:0]                    req, stb, we, gnt, acc, rvalid;
    logic [1:0][MM_ADDR_WIDTH-1:0] addr;
    logic [1:0][MM_DATA_WIDTH-1:0] wdata, rdata;
    logic                          rd_pending, rd_accept, hold_expired, revoke;

    assign req   = {bus.m1_req_i,   bus.m0_req_i};
    assign stb   = {bus.m1_stb_i,   bus.m0_stb_i};
    assign we    = {bus.m1_we_i,    bus.m0_we_i};
    assign addr  = {bus.m1_addr_i,  bus.m0_addr_i};
    assign wdata = {bus.m1_wdata_i, bus.m0_wdata_i};

    // Grant follows req combinationally so a release takes effect in the same cycle.
    assign gnt[0]    = (state_reg == OWN0) && req[0];
    assign gnt[1]    = (state_reg == OWN1) && req[1];
    assign acc       = gnt & stb;
    assign rd_accept = |(acc & ~we);
    assign revoke    = (|gnt) && hold_expired;
    assign own       = (state_reg == OWN1) ? M1 : M0;

`ifdef MM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
    logic [CNT_W-1:0] hold_cnt_reg;
    logic             timeout_reg;

    assign hold_expired = (hold_cnt_reg == CNT_W'(HOLD_LIMIT - 1));

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            // Only granted cycles count, so every pass through IDLE restarts it.
            hold_cnt_reg <= ((|gnt) && !revoke) ? hold_cnt_reg + 1'b1 : '0;
            timeout_reg  <= revoke;
        end
    end

    assign bus.arb_timeout_o = timeout_reg;
`else
    // Unbounded ownership; HOLD_LIMIT only matters in the timeout build.
    assign hold_expired      = 1'b0 & (HOLD_LIMIT > 0);
    assign bus.arb_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            last_reg  <= M1;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (req[0] && (!req[1] || last_reg == M1)) begin
                    state_next = OWN0;
                    last_next  = M0;
                end else if (req[1]) begin
                    state_next = OWN1;
                    last_next  = M1;
                end
            end
            OWN0, OWN1: begin
                if (!(|gnt)) begin
                    state_next = rd_pending ? DRAIN : IDLE;
                end else if (revoke) begin
                    // A read accepted in the revoke cycle still has to be returned.
                    state_next = (rd_pending || rd_accept) ? DRAIN : IDLE;
                    last_next  = own;
                end
            end
            DRAIN: begin
                if (!rd_pending) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mm_arb_mux #(
        .AW (MM_ADDR_WIDTH),
        .DW (MM_DATA_WIDTH)
    ) u_mux (
        .clk        (clk_sys_i),
        .rst        (rst_i),
        .acc        (acc),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .s_rdata    (bus.s_rdata_i),
        .s_addr     (bus.s_addr_o),
        .s_wdata    (bus.s_wdata_o),
        .s_we       (bus.s_we_o),
        .rd_pending (rd_pending),
        .rvalid     (rvalid),
        .rdata      (rdata)
    );

    assign bus.m0_gnt_o    = gnt[0];
    assign bus.m1_gnt_o    = gnt[1];
    assign bus.arb_owner_o = gnt;
    assign bus.m0_rvalid_o = rvalid[0];
    assign bus.m1_rvalid_o = rvalid[1];
    assign bus.m0_rdata_o  = rdata[0];
    assign bus.m1_rdata_o  = rdata[1];

endmodule

// File: tb/tb_mm_arbiter.sv
// Bench for mm_arbiter: directed and randomized ownership sessions checked against
// a cycle-indexed schedule of expected grants, bus transfers and read returns.
`timescale 1ns/1ps
module tb_mm_arbiter;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int HL   = 16;
    localparam int MAXK = 80;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mm_arbiter #(
        .MM_ADDR_WIDTH (AW),
        .MM_DATA_WIDTH (DW),
        .HOLD_LIMIT    (HL)
    ) dut (
        .clk_sys_i (clk),
        .rst_i     (rst),
        .bus       (bus)
    );

    logic [1:0]    req_d, stb_d, we_d;
    logic [AW-1:0] addr_d [2];
    logic [DW-1:0] wd_d [2];
    logic [DW-1:0] mem [256];

    assign bus.m0_req_i   = req_d[0];
    assign bus.m1_req_i   = req_d[1];
    assign bus.m0_stb_i   = stb_d[0];
    assign bus.m1_stb_i   = stb_d[1];
    assign bus.m0_we_i    = we_d[0];
    assign bus.m1_we_i    = we_d[1];
    assign bus.m0_addr_i  = addr_d[0];
    assign bus.m1_addr_i  = addr_d[1];
    assign bus.m0_wdata_i = wd_d[0];
    assign bus.m1_wdata_i = wd_d[1];
    // Memory answers in the cycle the registered address is on the bus.
    assign bus.s_rdata_i  = mem[bus.s_addr_o];

    logic [1:0]    gnt_o, rv_o;
    logic [DW-1:0] rd_o [2];
    logic [63:0]   snap;
    assign gnt_o = {bus.m1_gnt_o, bus.m0_gnt_o};
    assign rv_o  = {bus.m1_rvalid_o, bus.m0_rvalid_o};
    assign rd_o[0] = bus.m0_rdata_o;
    assign rd_o[1] = bus.m1_rdata_o;
    assign snap = {bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o,
                   bus.m0_rdata_o, bus.m1_rdata_o, bus.s_addr_o, bus.s_wdata_o,
                   bus.s_we_o, bus.arb_owner_o, bus.arb_timeout_o};

    int n_checks = 0;
    int n_fail   = 0;
    int last_served;
    int sess_id = 0;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wd;

    bit            t_stb [MAXK];
    bit            t_we  [MAXK];
    logic [AW-1:0] t_addr[MAXK];
    logic [DW-1:0] t_wd  [MAXK];

    bit            ev_v   [MAXK];
    bit            ev_we  [MAXK];
    logic [AW-1:0] ev_addr[MAXK];
    logic [DW-1:0] ev_wd  [MAXK];
    bit            rv_v   [MAXK];
    logic [DW-1:0] rv_d   [MAXK];

    task automatic clear_tables();
        for (int k = 0; k < MAXK; k++) begin
            t_stb[k] = 1'b0; t_we[k] = 1'b0; t_addr[k] = '0; t_wd[k] = '0;
        end
    endtask

    task automatic idle_inputs();
        req_d = '0; stb_d = '0; we_d = '0;
        for (int i = 0; i < 2; i++) begin
            addr_d[i] = '0; wd_d[i] = '0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (snap !== 64'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", snap, 64'h0);
        end
        rst = 1'b0;
        last_served = 1; cur_addr = '0; cur_wd = '0;
        @(posedge clk); #1;
        $display("reset: outputs checked at zero, last-served = m1");
    endtask

    // One ownership session: requests raised at k=0, the winner owns k=1..len.
    task automatic run_session(input bit r0, input bit r1, input int len, input string tag);
        int win, lose, next_gnt, last_rv;
        bit both, exp_g;
        logic [1:0] exp_gv, exp_rv;
        both = r0 && r1;
        win  = both ? ((last_served == 1) ? 0 : 1) : (r0 ? 0 : 1);
        lose = 1 - win;
        next_gnt = -1; last_rv = 0;
        for (int k = 0; k < MAXK; k++) begin
            ev_v[k] = 1'b0; ev_we[k] = 1'b0; rv_v[k] = 1'b0;
        end
        for (int k = 0; k <= len + 6; k++) begin
            // Next owner: one IDLE cycle after both the release and the last read return.
            if (both && k == len + 1)
                next_gnt = ((last_rv > len + 1) ? last_rv : len + 1) + 2;
            req_d[win] = (k <= len);
            if (k >= 1 && k <= len) begin
                stb_d[win] = t_stb[k]; we_d[win] = t_we[k];
                addr_d[win] = t_addr[k]; wd_d[win] = t_wd[k];
            end else begin
                stb_d[win] = 1'($urandom); we_d[win] = 1'($urandom);
                addr_d[win] = AW'($urandom); wd_d[win] = DW'($urandom);
            end
            req_d[lose]  = both && (next_gnt < 0 || k <= next_gnt);
            stb_d[lose]  = (next_gnt < 0 || k < next_gnt) ? 1'($urandom) : 1'b0;
            we_d[lose]   = 1'($urandom);
            addr_d[lose] = AW'($urandom);
            wd_d[lose]   = DW'($urandom);
            exp_g = (k >= 1 && k <= len);
            if (exp_g && stb_d[win]) begin
                ev_v[k+1] = 1'b1; ev_we[k+1] = we_d[win];
                ev_addr[k+1] = addr_d[win]; ev_wd[k+1] = wd_d[win];
                if (!we_d[win]) begin
                    rv_v[k+2] = 1'b1; rv_d[k+2] = mem[addr_d[win]]; last_rv = k + 2;
                end
            end
            exp_gv = '0; exp_gv[win] = exp_g; exp_gv[lose] = both && (k == next_gnt);
            exp_rv = '0; exp_rv[win] = rv_v[k];
            @(negedge clk);
            if (ev_v[k]) begin
                cur_addr = ev_addr[k]; cur_wd = ev_wd[k];
            end
            n_checks++;
            if (gnt_o !== exp_gv) begin
                n_fail++; $display("FAIL %s gnt k=%0d: got %b expected %b", tag, k, gnt_o, exp_gv);
            end
            n_checks++;
            if (bus.arb_owner_o !== exp_gv) begin
                n_fail++; $display("FAIL %s owner k=%0d: got %b expected %b", tag, k, bus.arb_owner_o, exp_gv);
            end
            n_checks++;
            if (bus.s_we_o !== (ev_v[k] && ev_we[k])) begin
                n_fail++; $display("FAIL %s s_we k=%0d: got %b expected %b", tag, k, bus.s_we_o, ev_v[k] && ev_we[k]);
            end
            n_checks++;
            if (bus.s_addr_o !== cur_addr) begin
                n_fail++; $display("FAIL %s s_addr k=%0d: got %h expected %h", tag, k, bus.s_addr_o, cur_addr);
            end
            n_checks++;
            if (bus.s_wdata_o !== cur_wd) begin
                n_fail++; $display("FAIL %s s_wdata k=%0d: got %h expected %h", tag, k, bus.s_wdata_o, cur_wd);
            end
            n_checks++;
            if (rv_o !== exp_rv) begin
                n_fail++; $display("FAIL %s rvalid k=%0d: got %b expected %b", tag, k, rv_o, exp_rv);
            end
            if (rv_v[k]) begin
                n_checks++;
                if (rd_o[win] !== rv_d[k]) begin
                    n_fail++; $display("FAIL %s rdata k=%0d: got %h expected %h", tag, k, rd_o[win], rv_d[k]);
                end
            end
            n_checks++;
            if (bus.arb_timeout_o !== 1'b0) begin
                n_fail++; $display("FAIL %s timeout k=%0d: got %b expected 0", tag, k, bus.arb_timeout_o);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        last_served = both ? lose : win;
        sess_id++;
        $display("session %0d %s: req=%b%b owner m%0d len %0d next_gnt %0d", sess_id, tag, r1, r0, win, len, next_gnt);
    endtask

    task automatic test_write();
        clear_tables();
        t_stb[1] = 1'b1; t_we[1] = 1'b1; t_addr[1] = 8'h10; t_wd[1] = 16'hA5A5;
        run_session(1'b1, 1'b0, 1, "write");
    endtask

    task automatic test_burst_read();
        mem[8'h20] = 16'h1111; mem[8'h21] = 16'h2222; mem[8'h22] = 16'h3333;
        clear_tables();
        for (int k = 1; k <= 3; k++) begin
            t_stb[k] = 1'b1; t_we[k] = 1'b0; t_addr[k] = AW'(8'h1F + k);
        end
        run_session(1'b0, 1'b1, 3, "burst_read");
    endtask

    task automatic test_fairness();
        test_reset();
        clear_tables();
        run_session(1'b1, 1'b1, 2, "fair_first");
        run_session(1'b1, 1'b1, 2, "fair_again");
    endtask

    task automatic test_drain();
        clear_tables();
        for (int k = 1; k <= 3; k++) begin
            t_stb[k] = 1'b1; t_we[k] = 1'b0; t_addr[k] = AW'($urandom);
        end
        run_session(1'b1, 1'b1, 3, "drain");
    endtask

    task automatic test_random();
        int sel, len;
        for (int s = 0; s < 25; s++) begin
            clear_tables();
            sel = $urandom_range(1, 3);
            len = $urandom_range(1, 12);
            for (int k = 1; k <= len; k++) begin
                t_stb[k]  = ($urandom_range(0, 3) != 0);
                t_we[k]   = 1'($urandom);
                t_addr[k] = AW'($urandom);
                t_wd[k]   = DW'($urandom);
            end
            run_session(sel[0], sel[1], len, "random");
        end
    endtask

`ifdef MM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [1:0] exp_gv;
        bit exp_to;
        test_reset();
        for (int k = 0; k <= 25; k++) begin
            req_d[0] = (k <= 22);
            req_d[1] = (k <= 18);
            exp_gv[0] = (k >= 1 && k <= HL) || (k >= 21 && k <= 22);
            exp_gv[1] = (k == HL + 2);
            exp_to    = (k == HL + 1);
            @(negedge clk);
            n_checks++;
            if (gnt_o !== exp_gv) begin
                n_fail++; $display("FAIL timeout gnt k=%0d: got %b expected %b", k, gnt_o, exp_gv);
            end
            n_checks++;
            if (bus.arb_timeout_o !== exp_to) begin
                n_fail++; $display("FAIL timeout pulse k=%0d: got %b expected %b", k, bus.arb_timeout_o, exp_to);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        last_served = 0;
        $display("timeout: m0 revoked after %0d cycles, m1 granted, m0 re-granted", HL);
    endtask
`else
    task automatic test_unbounded();
        clear_tables();
        run_session(1'b1, 1'b1, 40, "unbounded");
    endtask
`endif

    task automatic test_reset_mid_burst();
        test_reset();
        for (int k = 0; k <= 4; k++) begin
            req_d[1] = 1'b1;
            stb_d[1] = (k >= 1); we_d[1] = 1'b0; addr_d[1] = AW'($urandom);
            if (k >= 3) begin
                @(negedge clk);
                n_checks++;
                if (rv_o !== 2'b10) begin
                    n_fail++; $display("FAIL midreset rvalid_before k=%0d: got %b expected 10", k, rv_o);
                end
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
            end
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (snap !== 64'h0) begin
            n_fail++; $display("FAIL midreset async_outputs: got %h expected %h", snap, 64'h0);
        end
        idle_inputs();
        @(posedge clk); #3 rst = 1'b0;
        last_served = 1; cur_addr = '0; cur_wd = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (snap !== 64'h0) begin
                n_fail++; $display("FAIL midreset after_release k=%0d: got %h expected %h", k, snap, 64'h0);
            end
            @(posedge clk); #1;
        end
        $display("reset_mid_burst: outputs cleared, no stale rvalid after release");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        test_reset();
        test_write();
        test_burst_read();
        test_fairness();
        test_drain();
        test_random();
`ifdef MM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_unbounded();
`endif
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
